// File: rtl/snake_pkg.sv
// Shared types for the snake board: headings, coordinates and board size.
package snake_pkg;

    localparam int BOARD_N = 16;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        DIR_W = 2'b00,
        DIR_A = 2'b01,
        DIR_S = 2'b10,
        DIR_D = 2'b11
    } dir_t;

    // W<->S and A<->D differ only in the upper bit of the encoding.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/segment_fifo.sv
// Circular history of body cells {row, col}; oldest entry at the read pointer.
module segment_fifo
    import snake_pkg::*;
#(
    parameter int START_X   = 8,
    parameter int START_Y   = 8,
    parameter int START_LEN = 3,
    parameter int MAX_LEN   = 16,
    localparam int PW = $clog2(MAX_LEN),
    localparam int CW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  coord_t        push_x,
    input  coord_t        push_y,
    output coord_t        tail_x,
    output coord_t        tail_y,
    output logic [CW-1:0] count
);

    coord_t        x_q [MAX_LEN];
    coord_t        x_d [MAX_LEN];
    coord_t        y_q [MAX_LEN];
    coord_t        y_d [MAX_LEN];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (push) begin
            x_d[wr_q] = push_x;
            y_d[wr_q] = push_y;
            wr_d      = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
    end

    // Preload: entry 0 is the far end of the starting body (the oldest segment).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                x_q[i] <= (i < START_LEN - 1) ? coord_t'(START_X) : '0;
                y_q[i] <= (i < START_LEN - 1) ? coord_t'(START_Y + START_LEN - 1 - i) : '0;
            end
            rd_q  <= '0;
            wr_q  <= PW'(START_LEN - 1);
            cnt_q <= CW'(START_LEN - 1);
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign tail_x = x_q[rd_q];
    assign tail_y = y_q[rd_q];
    assign count  = cnt_q;

endmodule

// File: rtl/snake_mover.sv
// Snake movement engine: head position, heading, body history and bitmaps,
// advanced one cell per tick until the collision detector reports a death.
module snake_mover
    import snake_pkg::*;
#(
    parameter int START_X   = 8,
    parameter int START_Y   = 8,
    parameter int START_LEN = 3,
    parameter int MAX_LEN   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic [1:0]        dirReq,
    input  logic              dirValid,
    input  logic              grow,
    input  logic              died,
    output logic [3:0]        snakeHeadX,
    output logic [3:0]        snakeHeadY,
    output logic [1:0]        snakeDirection,
    output logic [15:0][15:0] GrnPixels,
    output logic [15:0][15:0] RedPixels,
    output logic              stepDone,
    output logic [4:0]        length
);

    localparam int CW = $clog2(MAX_LEN + 1);

    coord_t            head_x_q, head_x_d;
    coord_t            head_y_q, head_y_d;
    dir_t              dir_q, dir_d;
    dir_t              pend_q, pend_d;
    logic              grow_q, grow_d;
    logic              step_q, step_d;
    logic [15:0][15:0] green_q, green_d;

    logic              step_go, move, off_board, push, pop, grow_eff;
    coord_t            next_x, next_y, tail_x, tail_y;
    logic [CW-1:0]     body_cnt;

    function automatic logic [15:0][15:0] init_green();
        logic [15:0][15:0] g;
        g = '0;
        for (int i = 1; i < START_LEN; i++) begin
            g[START_X][START_Y + i] = 1'b1;
        end
        return g;
    endfunction

    segment_fifo #(
        .START_X  (START_X),
        .START_Y  (START_Y),
        .START_LEN(START_LEN),
        .MAX_LEN  (MAX_LEN)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .push_x (head_x_q),
        .push_y (head_y_q),
        .tail_x (tail_x),
        .tail_y (tail_y),
        .count  (body_cnt)
    );

    assign length = 5'(body_cnt) + 5'd1;

    always_comb begin
        step_go   = tick && !died && !step_q;
        grow_eff  = grow_q || grow;
        next_x    = head_x_q;
        next_y    = head_y_q;
        off_board = 1'b0;
        // The step always follows the heading pending before this edge.
        case (pend_q)
            DIR_W:   begin off_board = (head_x_q == 4'd0);  next_x = head_x_q - 1'b1; end
            DIR_S:   begin off_board = (head_x_q == 4'd15); next_x = head_x_q + 1'b1; end
            DIR_A:   begin off_board = (head_y_q == 4'd15); next_y = head_y_q + 1'b1; end
            default: begin off_board = (head_y_q == 4'd0);  next_y = head_y_q - 1'b1; end
        endcase
        move = step_go && !off_board;
        push = move;
        pop  = move && (!grow_eff || (length == 5'(MAX_LEN)));

        head_x_d = move ? next_x : head_x_q;
        head_y_d = move ? next_y : head_y_q;
        dir_d    = step_go ? pend_q : dir_q;
        grow_d   = step_go ? 1'b0 : grow_eff;
        step_d   = step_go;

        pend_d = pend_q;
        if (dirValid && (dir_t'(dirReq) != opposite(dir_q))) begin
            pend_d = dir_t'(dirReq);
        end

        // Clear before set so a tail cell re-entered by the old head stays lit.
        green_d = green_q;
        if (pop) begin
            green_d[tail_x][tail_y] = 1'b0;
        end
        if (push) begin
            green_d[head_x_q][head_y_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_x_q <= coord_t'(START_X);
            head_y_q <= coord_t'(START_Y);
            dir_q    <= DIR_D;
            pend_q   <= DIR_D;
            grow_q   <= 1'b0;
            step_q   <= 1'b0;
            green_q  <= init_green();
        end else begin
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            grow_q   <= grow_d;
            step_q   <= step_d;
            green_q  <= green_d;
        end
    end

    always_comb begin
        RedPixels                     = '0;
        RedPixels[head_x_q][head_y_q] = 1'b1;
    end

    assign snakeHeadX     = head_x_q;
    assign snakeHeadY     = head_y_q;
    assign snakeDirection = dir_q;
    assign GrnPixels      = green_q;
    assign stepDone       = step_q;

endmodule
